// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between an instruction-fetch requester (I)
// and a data load/store requester (D). Only one transaction is in flight at a
// time. Each transaction runs IDLE -> ACCESS (LATENCY cycles) -> DONE (one
// cycle, ack pulse) -> IDLE. When both sides request in the same IDLE cycle,
// the side that was not granted last wins. After reset, the last grant is I,
// so D wins the first contention.
//
// Parameters
//   ADDR_W   address width of every address port
//   DATA_W   data width of every data port
//   LATENCY  memory access cycles per transaction (1..15)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   i_req, i_addr             fetch request and address (held until i_ack)
//   i_ack, i_data             fetch completion pulse and fetched word
//   d_req, d_wr, d_addr,
//   d_wdata                   data request (d_wr=1 store, 0 load)
//   d_ack, d_rdata            data completion pulse and load result
//   mem_en, mem_wr, mem_addr,
//   mem_wdata, mem_rdata      shared memory interface
//   busy                      high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  // 0 = I was granted last, 1 = D was granted last
  logic       last_grant;
  // 1 = the transaction in flight belongs to D
  logic       sel_d;
  logic       grant_d;

  // D wins when it is the only requester, or when both request and I was
  // granted last time.
  assign grant_d = d_req & (~i_req | ~last_grant);

  // The memory-side registers double as the latched request: they are loaded
  // once on leaving IDLE and cleared on leaving ACCESS, so requester inputs
  // changing mid-transaction can never reach the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b0;
      sel_d      <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_data     <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            sel_d     <= grant_d;
            mem_en    <= 1'b1;
            mem_wr    <= grant_d & d_wr;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            cnt       <= CNT_INIT;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            // Last access cycle: mem_rdata is valid now. A store leaves
            // d_rdata untouched.
            if (sel_d) begin
              if (!mem_wr) begin
                d_rdata <= mem_rdata;
              end
              d_ack <= 1'b1;
            end else begin
              i_data <= mem_rdata;
              i_ack  <= 1'b1;
            end
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          i_ack      <= 1'b0;
          d_ack      <= 1'b0;
          last_grant <= sel_d;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Testbench for mem_arbiter (LATENCY=4). Memory read data is a function of the
// current address and cycle number, so a capture on the wrong cycle or from
// the wrong address shows up as a data error.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_data;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int cyc;
  int checks;
  int passes;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_data    (i_data),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory contents that change every cycle: value depends on address and cycle.
  function automatic logic [15:0] rd_hash(input logic [15:0] a, input int c);
    return ({a[7:0], a[15:8]} ^ 16'h5A5A) + c[15:0];
  endfunction

  assign mem_rdata = rd_hash(mem_addr, cyc);

  // Watchdog so the bench always ends even if something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to the next cycle; the cycle number changes just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clearInputs();
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  // Leaves the bench just after the release edge, in IDLE cycle 0.
  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: one row per cycle, outputs checked then inputs driven
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          ireq;
    logic [15:0]   iaddr;
    logic          dreq;
    logic          dwr;
    logic [15:0]   daddr;
    logic [15:0]   dwdata;
    logic          e_en;
    logic          e_wr;
    logic [15:0]   e_addr;
    logic [15:0]   e_wdata;
    logic          e_iack;
    logic          e_dack;
    logic          e_busy;
    logic [15:0]   e_idata;
    logic [15:0]   e_drdata;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  function automatic vec_t mkv(
    input logic ireq, input logic [15:0] iaddr,
    input logic dreq, input logic dwr, input logic [15:0] daddr, input logic [15:0] dwdata,
    input logic en, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
    input logic iack, input logic dack, input logic bsy,
    input logic [15:0] idata, input logic [15:0] drdata);
    vec_t v;
    v.ireq = ireq;   v.iaddr = iaddr;
    v.dreq = dreq;   v.dwr = dwr;   v.daddr = daddr;   v.dwdata = dwdata;
    v.e_en = en;     v.e_wr = wr;   v.e_addr = addr;   v.e_wdata = wdata;
    v.e_iack = iack; v.e_dack = dack; v.e_busy = bsy;
    v.e_idata = idata; v.e_drdata = drdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    i_req   = v.ireq;
    i_addr  = v.iaddr;
    d_req   = v.dreq;
    d_wr    = v.dwr;
    d_addr  = v.daddr;
    d_wdata = v.dwdata;
  endtask

  task automatic checkRow(input vec_t v, input int k);
    checkOutput($sformatf("row%0d mem_en", k),    32'(mem_en),    32'(v.e_en));
    checkOutput($sformatf("row%0d mem_wr", k),    32'(mem_wr),    32'(v.e_wr));
    checkOutput($sformatf("row%0d mem_addr", k),  32'(mem_addr),  32'(v.e_addr));
    checkOutput($sformatf("row%0d mem_wdata", k), 32'(mem_wdata), 32'(v.e_wdata));
    checkOutput($sformatf("row%0d i_ack", k),     32'(i_ack),     32'(v.e_iack));
    checkOutput($sformatf("row%0d d_ack", k),     32'(d_ack),     32'(v.e_dack));
    checkOutput($sformatf("row%0d busy", k),      32'(busy),      32'(v.e_busy));
    checkOutput($sformatf("row%0d i_data", k),    32'(i_data),    32'(v.e_idata));
    checkOutput($sformatf("row%0d d_rdata", k),   32'(d_rdata),   32'(v.e_drdata));
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a transaction starting in IDLE cycle s occupies the memory
  // in cycles s+1..s+LAT, acks in s+LAT+1, and the arbiter is idle again in
  // s+LAT+2. Read data is what the memory shows in cycle s+LAT.
  // ---------------------------------------------------------------------------
  bit          m_act;
  int          m_s;
  bit          m_is_d;
  bit          m_last_d;
  logic [15:0] m_addr;
  bit          m_wr;
  logic [15:0] m_wd;
  logic [15:0] m_idata;
  logic [15:0] m_drdata;

  logic        x_en, x_wr, x_iack, x_dack, x_busy;
  logic [15:0] x_addr, x_wdata;

  task automatic modelReset();
    m_act = 0; m_s = 0; m_is_d = 0; m_last_d = 0;
    m_addr = '0; m_wr = 0; m_wd = '0;
    m_idata = '0; m_drdata = '0;
  endtask

  // Called just after an edge; the inputs still hold what the edge sampled.
  task automatic modelAdvance();
    int p;
    p = cyc - 1;
    if (!m_act) begin
      if (i_req || d_req) begin
        if (i_req && d_req) m_is_d = !m_last_d;
        else                m_is_d = d_req;
        m_act  = 1;
        m_s    = p;
        m_addr = m_is_d ? d_addr : i_addr;
        m_wr   = m_is_d && d_wr;
        m_wd   = m_is_d ? d_wdata : 16'h0000;
      end
    end else if (p == m_s + LAT + 1) begin
      m_act    = 0;
      m_last_d = m_is_d;
    end else if (p == m_s + LAT) begin
      if (!m_is_d)   m_idata  = rd_hash(m_addr, p);
      else if (!m_wr) m_drdata = rd_hash(m_addr, p);
    end
  endtask

  task automatic modelExpect();
    int k;
    k = cyc - m_s;
    x_en = 0; x_wr = 0; x_addr = '0; x_wdata = '0;
    x_iack = 0; x_dack = 0; x_busy = m_act;
    if (m_act && k >= 1 && k <= LAT) begin
      x_en = 1; x_wr = m_wr; x_addr = m_addr; x_wdata = m_wd;
    end
    if (m_act && k == LAT + 1) begin
      x_iack = !m_is_d;
      x_dack = m_is_d;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] fv, lv;
    int d_first, d_second, i_first, both, first_ack;
    logic [15:0] addr7;
    int acks[$];
    int idles[$];
    bit i_pend, d_pend;

    checks = 0;
    passes = 0;
    cyc    = 0;
    rst    = 1'b1;
    clearInputs();

    fv = rd_hash(16'h0010, 4);
    lv = rd_hash(16'h0080, 16);

    // fetch of 0x0010
    tbl[0]  = mkv(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    tbl[1]  = mkv(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000);
    tbl[2]  = mkv(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000);
    tbl[3]  = mkv(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000);
    tbl[4]  = mkv(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000);
    tbl[5]  = mkv(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, fv, 16'h0000);
    // store of 0xBEEF to 0x0040, inputs disturbed mid-access
    tbl[6]  = mkv(0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, fv, 16'h0000);
    tbl[7]  = mkv(0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 1, fv, 16'h0000);
    tbl[8]  = mkv(0, 16'h0000, 1, 1, 16'h1234, 16'h1111, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 1, fv, 16'h0000);
    tbl[9]  = mkv(0, 16'h0000, 1, 1, 16'h1234, 16'h1111, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 1, fv, 16'h0000);
    tbl[10] = mkv(0, 16'h0000, 1, 1, 16'h1234, 16'h1111, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 1, fv, 16'h0000);
    tbl[11] = mkv(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, fv, 16'h0000);
    // load from 0x0080
    tbl[12] = mkv(0, 16'h0000, 1, 0, 16'h0080, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, fv, 16'h0000);
    tbl[13] = mkv(0, 16'h0000, 1, 0, 16'h0080, 16'h0000, 1, 0, 16'h0080, 16'h0000, 0, 0, 1, fv, 16'h0000);
    tbl[14] = mkv(0, 16'h0000, 1, 0, 16'h0080, 16'h0000, 1, 0, 16'h0080, 16'h0000, 0, 0, 1, fv, 16'h0000);
    tbl[15] = mkv(0, 16'h0000, 1, 0, 16'h0080, 16'h0000, 1, 0, 16'h0080, 16'h0000, 0, 0, 1, fv, 16'h0000);
    tbl[16] = mkv(0, 16'h0000, 1, 0, 16'h0080, 16'h0000, 1, 0, 16'h0080, 16'h0000, 0, 0, 1, fv, 16'h0000);
    tbl[17] = mkv(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, fv, lv);
    tbl[18] = mkv(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, fv, lv);

    doReset();
    for (int k = 0; k < NVEC; k++) begin
      checkRow(tbl[k], k);
      applyStimulus(tbl[k]);
      step();
    end

    // Contention: D first, then I (D re-requests), then D alone.
    doReset();
    i_req = 1'b1; i_addr = 16'h0100;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    d_first = -1; d_second = -1; i_first = -1; both = 0; addr7 = '0;
    for (int n = 0; n < 24; n++) begin
      step();
      if (cyc == 7) addr7 = mem_addr;
      if (i_ack && d_ack) both++;
      if (d_ack) begin
        if (d_first < 0) d_first = cyc;
        else if (d_second < 0) begin
          d_second = cyc;
          d_req = 1'b0;
        end
      end
      if (i_ack) begin
        if (i_first < 0) i_first = cyc;
        i_req = 1'b0;
      end
    end
    checkOutput("contention first d_ack cycle", 32'(d_first), 32'd5);
    checkOutput("contention i_ack cycle", 32'(i_first), 32'd11);
    checkOutput("contention second d_ack cycle", 32'(d_second), 32'd17);
    checkOutput("contention I address in cycle 7", 32'(addr7), 32'h0100);
    checkOutput("contention acks together", 32'(both), 32'd0);

    // Reset in the middle of an access drops the transaction.
    doReset();
    i_req = 1'b1; i_addr = 16'h0300;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset mid-access mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset mid-access busy", 32'(busy), 32'd0);
    checkOutput("reset mid-access mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset mid-access i_ack", 32'(i_ack), 32'd0);
    doReset();
    i_req = 1'b1; i_addr = 16'h0300;
    first_ack = -1;
    for (int n = 0; n < 12; n++) begin
      step();
      if (i_ack && first_ack < 0) begin
        first_ack = cyc;
        i_req = 1'b0;
      end
    end
    checkOutput("post-reset fetch i_ack cycle", 32'(first_ack), 32'(LAT + 1));
    checkOutput("post-reset fetch i_data", 32'(i_data), 32'(rd_hash(16'h0300, LAT)));

    // Continuous fetch: ack every LAT+2 cycles, one idle cycle in between.
    doReset();
    i_req = 1'b1; i_addr = 16'h0500;
    for (int n = 0; n < 23; n++) begin
      step();
      if (i_ack) acks.push_back(cyc);
      if (!busy) idles.push_back(cyc);
    end
    i_req = 1'b0;
    checkOutput("back-to-back ack count", 32'(acks.size()), 32'd4);
    for (int j = 0; j < acks.size() && j < 4; j++)
      checkOutput($sformatf("back-to-back ack %0d cycle", j), 32'(acks[j]), 32'(5 + 6 * j));
    checkOutput("back-to-back idle count", 32'(idles.size()), 32'd3);
    for (int j = 0; j < idles.size() && j < 3; j++)
      checkOutput($sformatf("back-to-back idle %0d cycle", j), 32'(idles[j]), 32'(6 + 6 * j));

    // Randomized traffic against the reference model.
    doReset();
    modelReset();
    i_pend = 0; d_pend = 0;
    for (int n = 0; n < 600; n++) begin
      modelExpect();
      checkOutput("rand mem_en",    32'(mem_en),    32'(x_en));
      checkOutput("rand mem_wr",    32'(mem_wr),    32'(x_wr));
      checkOutput("rand mem_addr",  32'(mem_addr),  32'(x_addr));
      checkOutput("rand mem_wdata", 32'(mem_wdata), 32'(x_wdata));
      checkOutput("rand i_ack",     32'(i_ack),     32'(x_iack));
      checkOutput("rand d_ack",     32'(d_ack),     32'(x_dack));
      checkOutput("rand busy",      32'(busy),      32'(x_busy));
      checkOutput("rand i_data",    32'(i_data),    32'(m_idata));
      checkOutput("rand d_rdata",   32'(d_rdata),   32'(m_drdata));

      if (x_iack) i_pend = 0;
      else if (!i_pend && $urandom_range(0, 3) == 0) i_pend = 1;
      if (x_dack) d_pend = 0;
      else if (!d_pend && $urandom_range(0, 3) == 0) d_pend = 1;

      // While its own access is running a requester may wobble its req.
      if (m_act && !m_is_d && x_en) i_req = 1'($urandom_range(0, 1));
      else                          i_req = i_pend;
      if (m_act && m_is_d && x_en)  d_req = 1'($urandom_range(0, 1));
      else                          d_req = d_pend;
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
      d_wr    = 1'($urandom_range(0, 1));

      step();
      modelAdvance();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, address width of every address port.
REQ-002 Parameter DATA_W, 16, data width of every data port.
REQ-003 Parameter LATENCY, 4, memory access cycles per transaction, legal range 1..15.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port i_req  in  1  instruction-fetch request, held until i_ack.
REQ-007 Port i_addr  in  ADDR_W  fetch address.
REQ-008 Port i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 Port i_data  out  DATA_W  fetched word, valid when i_ack=1, held until next fetch completion.
REQ-010 Port d_req  in  1  data request, held until d_ack.
REQ-011 Port d_wr  in  1  1 = store, 0 = load.
REQ-012 Port d_addr  in  ADDR_W  data address.
REQ-013 Port d_wdata  in  DATA_W  store data.
REQ-014 Port d_ack  out  1  one-cycle data completion pulse.
REQ-015 Port d_rdata  out  DATA_W  load result, valid when d_ack=1, held until next load completion.
REQ-016 Port mem_en  out  1  enable to the shared single-port memory.
REQ-017 Port mem_wr  out  1  write strobe to the memory.
REQ-018 Port mem_addr  out  ADDR_W  memory address.
REQ-019 Port mem_wdata  out  DATA_W  memory write data.
REQ-020 Port mem_rdata  in  DATA_W  memory read data.
REQ-021 Port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS, DONE; one transaction in flight at a time.
REQ-023 IDLE: if any req is high, select a winner, latch its addr/wr/wdata (fetch: wr=0, wdata=0), load cnt=LATENCY-1, go to ACCESS; otherwise stay.
REQ-024 Arbitration: a single requester wins outright; if both are high, the side not granted last wins (round-robin); last_grant resets to I, so D wins the first contention.
REQ-025 ACCESS: mem_en=1 and mem_addr/mem_wr/mem_wdata driven from latched values for exactly LATENCY cycles; cnt decrements each cycle.
REQ-026 ACCESS with cnt=0: capture mem_rdata into i_data (fetch) or d_rdata (load); store leaves d_rdata unchanged; go to DONE.
REQ-027 DONE: assert the winner's ack for exactly one cycle, mem_en=0, update last_grant, go to IDLE.
REQ-028 Timing: req sampled high in IDLE cycle t gives ACCESS cycles t+1..t+LATENCY, ack at t+LATENCY+1, IDLE at t+LATENCY+2; throughput is one transaction per LATENCY+2 cycles.
REQ-029 Requesters SHALL drop req at the edge ending their ack cycle; a req still high in IDLE is treated as a new request.
REQ-030 Changes on req/addr/wr/wdata inputs during ACCESS or DONE SHALL NOT affect the memory outputs or the transaction.
REQ-031 A req dropped mid-transaction SHALL NOT abort it; the ack still pulses.
REQ-032 mem_en, mem_wr, i_ack and d_ack SHALL never be high outside the states defined above; i_ack and d_ack are never high together.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, cnt=0, last_grant=I, and set every output to 0, including i_data and d_rdata.
REQ-034 rst asserted mid-transaction SHALL drop the transaction with no ack; the first IDLE cycle after release samples req normally.

Verification
REQ-035 With LATENCY=4, after reset, i_req=1 and i_addr=0x0010 at cycle 0 -> mem_en=1 and mem_addr=0x0010 with mem_wr=0 in cycles 1-4; i_ack=1 in cycle 5; i_data equals mem_rdata sampled in cycle 4.
REQ-036 With i_req and d_req both high at cycle 0 after reset -> D is served first with d_ack at cycle 5; I is granted in IDLE cycle 6 with i_ack at cycle 11; at the next contention I is served first.
REQ-037 Store with d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> mem_wr=1 and mem_wdata=0xBEEF in cycles 1-4; d_ack at cycle 5; d_rdata unchanged.
REQ-038 Changing d_addr to 0x1234 during ACCESS cycle 2 -> mem_addr stays 0x0040 through cycle 4.
REQ-039 rst pulsed during ACCESS cycle 2 -> mem_en=0 and busy=0 immediately; no ack; after release, a new i_req completes in LATENCY+1 cycles.
REQ-040 With i_req held high continuously -> back-to-back fetches, i_ack every 6 cycles, busy low for exactly one cycle between transactions.
